// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: CSRRW/S/C[I], synchronous exceptions,
// timer/external interrupts, MRET, and the 64-bit mcycle/minstret counters.
module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic [1:0]  csr_op,
    input  logic        csr_source,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_uimm,
    input  logic [31:0] rs1_data,
    input  logic        exc_request,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_tval,
    input  logic        is_mret,
    input  logic        irq_timer,
    input  logic        irq_ext,
    output logic [31:0] csr_rdata,
    output logic        illegal_csr,
    output logic        trap_taken,
    output logic [31:0] trap_pc,
    output logic        mret_taken,
    output logic [31:0] mepc_out
);

    typedef enum logic [1:0] {
        CSR_NONE  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_e;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [31:0] CAUSE_IRQ_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_IRQ_TIMER = 32'h8000_0007;

    logic        status_mie;
    logic        status_mpie;
    logic        mie_meie;
    logic        mie_mtie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    csr_op_e     op;
    logic [31:0] src;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;
    logic        implemented;
    logic        csr_active;
    logic        write_suppressed;
    logic        wants_write;
    logic        illegal;
    logic        exc;
    logic        ext_pend;
    logic        timer_pend;
    logic        irq;
    logic        trap;
    logic        mret;
    logic        do_write;
    logic        retire;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic [63:0] mcycle_next;
    logic [63:0] minstret_next;

    assign op          = csr_op_e'(csr_op);
    assign src         = csr_source ? {27'b0, rs1_uimm} : rs1_data;
    assign mstatus_val = {19'b0, 2'b11, 3'b0, status_mpie, 3'b0, status_mie, 3'b0};
    assign mie_val     = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
    assign mip_val     = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};

    // NOTE: every combinational output gets a default before the case, so no latch is inferred.
    always_comb begin
        old_val     = 32'h0;
        implemented = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:                  old_val = mstatus_val;
            ADDR_MISA:                     old_val = MISA_VALUE;
            ADDR_MIE:                      old_val = mie_val;
            ADDR_MTVEC:                    old_val = mtvec;
            ADDR_MSCRATCH:                 old_val = mscratch;
            ADDR_MEPC:                     old_val = mepc;
            ADDR_MCAUSE:                   old_val = mcause;
            ADDR_MTVAL:                    old_val = mtval;
            ADDR_MIP:                      old_val = mip_val;
            ADDR_MCYCLE, ADDR_CYCLE:       old_val = mcycle[31:0];
            ADDR_MCYCLEH, ADDR_CYCLEH:     old_val = mcycle[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:   old_val = minstret[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: old_val = minstret[63:32];
            ADDR_MHARTID:                  old_val = HART_ID;
            default:                       implemented = 1'b0;
        endcase
    end

    always_comb begin
        new_val = src;
        case (op)
            CSR_SET:   new_val = old_val | src;
            CSR_CLEAR: new_val = old_val & ~src;
            default:   new_val = src;
        endcase
    end

    // Set/clear with a zero rs1 index or uimm is a pure read, which keeps read-only counters legal.
    assign csr_active       = instr_valid && (op != CSR_NONE);
    assign write_suppressed = ((op == CSR_SET) || (op == CSR_CLEAR)) && (rs1_uimm == 5'd0);
    assign wants_write      = csr_active && !write_suppressed;
    assign illegal          = csr_active &&
                              (!implemented || ((csr_addr[11:10] == 2'b11) && wants_write));

    assign exc        = instr_valid && (exc_request || illegal);
    assign ext_pend   = mie_meie & irq_ext;
    assign timer_pend = mie_mtie & irq_timer;
    assign irq        = instr_valid && status_mie && (ext_pend || timer_pend) && !exc;
    assign trap       = exc || irq;
    assign mret       = instr_valid && is_mret && !trap;
    assign do_write   = wants_write && !trap && !mret;
    assign retire     = instr_valid && !trap;

    always_comb begin
        trap_cause = ext_pend ? CAUSE_IRQ_EXT : CAUSE_IRQ_TIMER;
        trap_tval  = 32'h0;
        if (exc_request) begin
            trap_cause = exc_cause;
            trap_tval  = exc_tval;
        end else if (illegal) begin
            trap_cause = CAUSE_ILLEGAL;
        end
    end

    // An explicit write to either counter half replaces that cycle's increment.
    always_comb begin
        mcycle_next   = mcycle + 64'd1;
        minstret_next = retire ? minstret + 64'd1 : minstret;
        if (do_write) begin
            case (csr_addr)
                ADDR_MCYCLE:    mcycle_next   = {mcycle[63:32], new_val};
                ADDR_MCYCLEH:   mcycle_next   = {new_val, mcycle[31:0]};
                ADDR_MINSTRET:  minstret_next = {minstret[63:32], new_val};
                ADDR_MINSTRETH: minstret_next = {new_val, minstret[31:0]};
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            mie_meie    <= 1'b0;
            mie_mtie    <= 1'b0;
            mtvec       <= {MTVEC_RESET[31:2], 2'b00};
            mscratch    <= 32'h0;
            mepc        <= 32'h0;
            mcause      <= 32'h0;
            mtval       <= 32'h0;
            mcycle      <= 64'h0;
            minstret    <= 64'h0;
        end else begin
            mcycle   <= mcycle_next;
            minstret <= minstret_next;
            if (trap) begin
                mepc        <= pc & ~32'h3;
                mcause      <= trap_cause;
                mtval       <= trap_tval;
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
            end else if (mret) begin
                status_mie  <= status_mpie;
                status_mpie <= 1'b1;
            end else if (do_write) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        status_mie  <= new_val[3];
                        status_mpie <= new_val[7];
                    end
                    ADDR_MIE: begin
                        mie_meie <= new_val[11];
                        mie_mtie <= new_val[7];
                    end
                    ADDR_MTVEC:    mtvec    <= new_val & ~32'h3;
                    ADDR_MSCRATCH: mscratch <= new_val;
                    ADDR_MEPC:     mepc     <= new_val & ~32'h3;
                    ADDR_MCAUSE:   mcause   <= new_val;
                    ADDR_MTVAL:    mtval    <= new_val;
                    default: ;
                endcase
            end
        end
    end

    assign csr_rdata   = rst ? 32'h0 : old_val;
    assign illegal_csr = !rst && illegal;
    assign trap_taken  = !rst && trap;
    assign trap_pc     = rst ? 32'h0 : mtvec;
    assign mret_taken  = !rst && mret;
    assign mepc_out    = rst ? 32'h0 : mepc;

endmodule
